// File: rtl/drive_sequencer.sv
// Drive-code sequencer between the movement system and the PWM generator.
// Each motor channel enforces soft-start ramp and reversal dead time, counted in PWM periods (E).

module drive_channel #(
    parameter int DEAD_PERIODS = 4,
    parameter int RAMP_PERIODS = 2,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       E,
    input  logic       Stop,
    input  logic       accept,
    input  logic [1:0] cmd,
    output logic [1:0] drive,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, RUN, RAMP, DEAD} state_t;

    typedef struct packed {
        state_t           st;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       tgt;
        logic [1:0]       drv;
    } chan_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_PERIODS);
    localparam logic [CNT_W-1:0] RAMP_LD = CNT_W'(RAMP_PERIODS);

    chan_t r;

    function automatic chan_t run_at(input logic [1:0] t);
        chan_t n;
        n.st  = (t == 2'd0) ? IDLE : RUN;
        n.cnt = '0;
        n.tgt = t;
        n.drv = t;
        return n;
    endfunction

    // Entry from stop or from the end of dead time: full speed forward needs the soft start first.
    function automatic chan_t settle(input logic [1:0] t);
        chan_t n;
        if (t == 2'd2 && RAMP_PERIODS != 0) begin
            n.st  = RAMP;
            n.cnt = RAMP_LD;
            n.tgt = t;
            n.drv = 2'd1;
        end else begin
            n = run_at(t);
        end
        return n;
    endfunction

    function automatic chan_t dead_on(input logic [1:0] t);
        chan_t n;
        n.st  = DEAD;
        n.cnt = DEAD_LD;
        n.tgt = t;
        n.drv = 2'd0;
        return n;
    endfunction

    function automatic logic reversal(input logic [1:0] c, input logic [1:0] t);
        return ((c == 2'd1 || c == 2'd2) && t == 2'd3) ||
               (c == 2'd3 && (t == 2'd1 || t == 2'd2));
    endfunction

    function automatic chan_t on_accept(input chan_t cur, input logic [1:0] t);
        chan_t n;
        n = cur;
        if (t != cur.drv) begin
            if (t == 2'd0)
                n = run_at(2'd0);
            else if (reversal(cur.drv, t))
                n = (DEAD_PERIODS != 0) ? dead_on(t) : settle(t);
            else if (cur.drv == 2'd0)
                n = settle(t);
            else
                n = run_at(t);
        end
        return n;
    endfunction

    function automatic chan_t on_period(input chan_t cur);
        chan_t n;
        n = cur;
        if (cur.st == DEAD || cur.st == RAMP) begin
            if (cur.cnt == ONE)
                n = (cur.st == DEAD) ? settle(cur.tgt) : run_at(cur.tgt);
            else if (cur.cnt != '0)
                n.cnt = cur.cnt - ONE;
        end
        return n;
    endfunction

    // Stop outranks a same-cycle accept; an accept outranks a same-cycle E (load wins).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r <= run_at(2'd0);
        else if (Stop)
            r <= run_at(2'd0);
        else if (accept)
            r <= on_accept(r, cmd);
        else if (E)
            r <= on_period(r);
    end

    assign drive = r.drv;
    assign busy  = (r.st == RAMP) || (r.st == DEAD);
endmodule

module drive_sequencer #(
    parameter int DEAD_PERIODS = 4,
    parameter int RAMP_PERIODS = 2,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       E,
    input  logic       Stop,
    input  logic       CmdValid,
    input  logic [1:0] CmdA,
    input  logic [1:0] CmdB,
    output logic       CmdReady,
    output logic [1:0] DriveA,
    output logic [1:0] DriveB,
    output logic       Busy
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][1:0] cmd;
    logic [NUM_LANES-1:0][1:0] drive;
    logic [NUM_LANES-1:0]      busy;
    logic                      accept;

    assign cmd      = {CmdB, CmdA};
    assign Busy     = |busy;
    assign CmdReady = ~RST & ~Stop & ~Busy;
    assign accept   = CmdValid & CmdReady;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
            drive_channel #(
                .DEAD_PERIODS(DEAD_PERIODS),
                .RAMP_PERIODS(RAMP_PERIODS),
                .CNT_W       (CNT_W)
            ) u_ch (
                .CLK   (CLK),
                .RST   (RST),
                .E     (E),
                .Stop  (Stop),
                .accept(accept),
                .cmd   (cmd[g]),
                .drive (drive[g]),
                .busy  (busy[g])
            );
        end
    endgenerate

    assign DriveA = drive[0];
    assign DriveB = drive[1];
endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: a default-parameter instance and a no-ramp/no-dead instance share stimulus,
// each tracked by a period-count model; directed sequences add literal expectations.

module tb_drive_sequencer;
    logic       CLK = 1'b0;
    logic       RST, E, Stop, CmdValid;
    logic [1:0] CmdA, CmdB;
    logic       rdy0, rdy1, busy0, busy1;
    logic [1:0] da0, db0, da1, db1;

    always #5 CLK = ~CLK;

    drive_sequencer #(.DEAD_PERIODS(4), .RAMP_PERIODS(2), .CNT_W(8)) dut0 (
        .CLK(CLK), .RST(RST), .E(E), .Stop(Stop), .CmdValid(CmdValid), .CmdA(CmdA), .CmdB(CmdB),
        .CmdReady(rdy0), .DriveA(da0), .DriveB(db0), .Busy(busy0));

    drive_sequencer #(.DEAD_PERIODS(0), .RAMP_PERIODS(0), .CNT_W(8)) dut1 (
        .CLK(CLK), .RST(RST), .E(E), .Stop(Stop), .CmdValid(CmdValid), .CmdA(CmdA), .CmdB(CmdB),
        .CmdReady(rdy1), .DriveA(da1), .DriveB(db1), .Busy(busy1));

    int total = 0;
    int bad   = 0;
    int ephase = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per channel, remaining dead periods, remaining ramp periods, and the target code.
    int m_dead[2][2];
    int m_ramp[2][2];
    int m_tgt [2][2];

    function automatic int dpar(input int u); return (u == 0) ? 4 : 0; endfunction
    function automatic int rpar(input int u); return (u == 0) ? 2 : 0; endfunction
    function automatic int cmd_of(input int ch); return (ch == 0) ? int'(CmdA) : int'(CmdB); endfunction

    function automatic int m_out(input int u, input int ch);
        if (m_dead[u][ch] > 0) return 0;
        if (m_ramp[u][ch] > 0) return 1;
        return m_tgt[u][ch];
    endfunction

    function automatic bit m_busy(input int u);
        return m_dead[u][0] > 0 || m_ramp[u][0] > 0 || m_dead[u][1] > 0 || m_ramp[u][1] > 0;
    endfunction

    function automatic bit is_rev(input int c, input int t);
        return ((c == 1 || c == 2) && t == 3) || (c == 3 && (t == 1 || t == 2));
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int u = 0; u < 2; u++)
                for (int ch = 0; ch < 2; ch++) begin
                    m_dead[u][ch] <= 0; m_ramp[u][ch] <= 0; m_tgt[u][ch] <= 0;
                end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (Stop) begin
                    for (int ch = 0; ch < 2; ch++) begin
                        m_dead[u][ch] <= 0; m_ramp[u][ch] <= 0; m_tgt[u][ch] <= 0;
                    end
                end else if (CmdValid && !m_busy(u)) begin
                    for (int ch = 0; ch < 2; ch++) begin
                        m_tgt[u][ch]  <= cmd_of(ch);
                        m_dead[u][ch] <= is_rev(m_out(u, ch), cmd_of(ch)) ? dpar(u) : 0;
                        m_ramp[u][ch] <= (cmd_of(ch) == 2 && (m_out(u, ch) == 0 || m_out(u, ch) == 3))
                                         ? rpar(u) : 0;
                    end
                end else if (E) begin
                    for (int ch = 0; ch < 2; ch++) begin
                        if (m_dead[u][ch] > 0)      m_dead[u][ch] <= m_dead[u][ch] - 1;
                        else if (m_ramp[u][ch] > 0) m_ramp[u][ch] <= m_ramp[u][ch] - 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (mon_on) begin
            chk("mon_driveA0", int'(da0), m_out(0, 0));
            chk("mon_driveB0", int'(db0), m_out(0, 1));
            chk("mon_busy0",   int'(busy0), int'(m_busy(0)));
            chk("mon_ready0",  int'(rdy0), int'(!RST && !Stop && !m_busy(0)));
            chk("mon_driveA1", int'(da1), m_out(1, 0));
            chk("mon_driveB1", int'(db1), m_out(1, 1));
            chk("mon_busy1",   int'(busy1), int'(m_busy(1)));
            chk("mon_ready1",  int'(rdy1), int'(!RST && !Stop && !m_busy(1)));
        end
    end

    // Inputs change 2 time units after the active edge; E is one CLK wide every 128 CLK.
    task automatic tick();
        @(posedge CLK);
        #2;
        ephase = (ephase + 1) % 128;
        E = (ephase == 0);
    endtask

    task automatic wait_e(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 1000) begin
            bit had = E;
            tick();
            if (had) k++;
            guard++;
        end
        if (k < n) chk("wait_e_timeout", k, n);
    endtask

    task automatic send(input logic [1:0] a, input logic [1:0] b);
        int guard = 0;
        while ((!rdy0 || E) && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) chk("send_ready_timeout", int'(rdy0), 1);
        CmdA = a; CmdB = b; CmdValid = 1'b1;
        tick();
        CmdValid = 1'b0;
    endtask

    initial begin
        RST = 1'b1; E = 1'b0; Stop = 1'b0; CmdValid = 1'b0; CmdA = 2'd0; CmdB = 2'd0;
        repeat (3) tick();
        mon_on = 1'b1;
        chk("rst_driveA", int'(da0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_ready", int'(rdy0), 0);
        RST = 1'b0;
        #1 chk("rst_release_ready", int'(rdy0), 1);

        // Start: A ramps 1 for two periods then 2; B straight to 1.
        send(2'd2, 2'd1);
        chk("start_A_ramp", int'(da0), 1);
        chk("start_B_run", int'(db0), 1);
        chk("start_busy", int'(busy0), 1);
        chk("start_ready_low", int'(rdy0), 0);
        chk("sweep_start_A", int'(da1), 2);
        chk("sweep_start_busy", int'(busy1), 0);
        wait_e(1);
        chk("start_A_after1E", int'(da0), 1);
        wait_e(1);
        chk("start_A_after2E", int'(da0), 2);
        chk("start_busy_end", int'(busy0), 0);
        chk("start_ready_end", int'(rdy0), 1);

        // Reverse: 2 -> 3 through four periods of dead time.
        send(2'd3, 2'd1);
        chk("rev_A_dead", int'(da0), 0);
        chk("rev_busy", int'(busy0), 1);
        chk("sweep_rev_A", int'(da1), 3);
        chk("sweep_rev_busy", int'(busy1), 0);
        wait_e(3);
        chk("rev_A_after3E", int'(da0), 0);
        chk("rev_ready_low", int'(rdy0), 0);
        wait_e(1);
        chk("rev_A_after4E", int'(da0), 3);
        chk("rev_ready_end", int'(rdy0), 1);

        // Coincidence: accept on an E edge; that E does not count toward the dead time.
        begin
            int guard = 0;
            while (!E && guard < 200) begin tick(); guard++; end
            if (!E) chk("coin_e_timeout", int'(E), 1);
        end
        CmdA = 2'd1; CmdB = 2'd1; CmdValid = 1'b1;
        tick();
        CmdValid = 1'b0;
        chk("coin_A_dead", int'(da0), 0);
        wait_e(3);
        chk("coin_A_after3E", int'(da0), 0);
        wait_e(1);
        chk("coin_A_after4E", int'(da0), 1);

        // Stop mid-ramp with a command pending: both off, command dropped, nothing resumes.
        send(2'd0, 2'd1);
        chk("stop_now_A", int'(da0), 0);
        chk("stop_now_busy", int'(busy0), 0);
        send(2'd2, 2'd3);
        chk("stopt_A_ramp", int'(da0), 1);
        chk("stopt_B_dead", int'(db0), 0);
        wait_e(1);
        Stop = 1'b1; CmdValid = 1'b1; CmdA = 2'd1; CmdB = 2'd1;
        #1 chk("stop_ready_low", int'(rdy0), 0);
        tick();
        chk("stop_A", int'(da0), 0);
        chk("stop_B", int'(db0), 0);
        chk("stop_busy", int'(busy0), 0);
        chk("stop_sweep_B", int'(db1), 0);
        Stop = 1'b0; CmdValid = 1'b0;
        wait_e(3);
        chk("stop_A_held", int'(da0), 0);
        chk("stop_B_held", int'(db0), 0);

        // Reset asserted mid-dead: outputs clear at once and no sequence resumes.
        send(2'd1, 2'd0);
        chk("rstd_A_run", int'(da0), 1);
        send(2'd3, 2'd0);
        chk("rstd_A_dead", int'(da0), 0);
        wait_e(2);
        RST = 1'b1;
        #1;
        chk("rstd_A", int'(da0), 0);
        chk("rstd_busy", int'(busy0), 0);
        chk("rstd_ready", int'(rdy0), 0);
        tick();
        RST = 1'b0;
        #1 chk("rstd_ready_after", int'(rdy0), 1);
        wait_e(3);
        chk("rstd_A_held", int'(da0), 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
